lsa_scan_scheduler: RTL and testbench

Sequences conversions on the line-sensor-array SPI ADC engine across NUM_CH channels, so the engine converts one channel per request. The scheduler issues per-channel conversion requests and buffers results in a shadow bank. It commits a coherent frame of samples plus thresholded line bits to the motor-control logic. It sits between the ADC serial engine and the line-follow controller.

---
 rtl/lsa_scan_scheduler_if.sv | 32 +++
 rtl/lsa_scan_scheduler.sv | 169 ++++++++++++++++
 tb/tb_lsa_scan_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsa_scan_scheduler_if.sv
// Bundle between the scan scheduler, the SPI ADC engine and the line-follow controller.
// The master modport is the scheduler side, the slave modport is its environment.
interface lsa_scan_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 12
);
  logic                     enable;
  logic                     single_shot;
  logic [NUM_CH-1:0]        ch_mask;
  logic [DATA_W-1:0]        thresh;
  logic                     err_clr;
  logic                     conv_req;
  logic [2:0]               conv_ch;
  logic                     conv_ack;
  logic                     conv_done;
  logic [DATA_W-1:0]        conv_data;
  logic [NUM_CH*DATA_W-1:0] sample_out;
  logic [NUM_CH-1:0]        line_bits;
  logic                     frame_valid;
  logic                     busy;
  logic                     timeout_err;

  modport master (
    input  enable, single_shot, ch_mask, thresh, err_clr, conv_ack, conv_done, conv_data,
    output conv_req, conv_ch, sample_out, line_bits, frame_valid, busy, timeout_err
  );

  modport slave (
    output enable, single_shot, ch_mask, thresh, err_clr, conv_ack, conv_done, conv_data,
    input  conv_req, conv_ch, sample_out, line_bits, frame_valid, busy, timeout_err
  );
endinterface

// File: rtl/lsa_scan_scheduler.sv
// Walks the latched channel mask one ADC conversion at a time into a shadow bank, then
// commits the bank plus thresholded line bits as one coherent frame.
module lsa_scan_scheduler #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 12,
  parameter int SCAN_GAP    = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input logic clk,
  input logic rst,
  lsa_scan_scheduler_if.master bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_REQ    = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;

  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GAP_W = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0] GAP_LAST = (SCAN_GAP > 0) ? 32'(SCAN_GAP - 1) : 32'd0;

  logic [2:0]                          state_q, state_d;
  logic [NUM_CH-1:0]                   frame_mask_q, frame_mask_d;
  logic [NUM_CH-1:0]                   serviced_q, serviced_d;
  logic [2:0]                          conv_ch_q, conv_ch_d;
  logic [TO_W-1:0]                     to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]                    gap_cnt_q, gap_cnt_d;
  logic [NUM_CH-1:0][DATA_W-1:0]       shadow_q, shadow_d;
  logic [NUM_CH-1:0][DATA_W-1:0]       sample_q, sample_d;
  logic [NUM_CH-1:0]                   line_q, line_d;
  logic                                fv_q, fv_d;
  logic                                err_q, err_d;

  logic [NUM_CH-1:0] pend;
  logic              pick_vld;
  logic [2:0]        pick_ch;
  logic              capture;
  logic              to_set;

  // Lowest-index channel of this frame that has not had its turn yet.
  always_comb begin
    pend     = frame_mask_q & ~serviced_q;
    pick_vld = |pend;
    pick_ch  = 3'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend[i]) pick_ch = 3'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    frame_mask_d = frame_mask_q;
    serviced_d   = serviced_q;
    conv_ch_d    = conv_ch_q;
    to_cnt_d     = to_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    shadow_d     = shadow_q;
    sample_d     = sample_q;
    line_d       = line_q;
    fv_d         = 1'b0;
    capture      = 1'b0;
    to_set       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if ((bus.single_shot || bus.enable) && (|bus.ch_mask)) begin
          frame_mask_d = bus.ch_mask;
          serviced_d   = '0;
          state_d      = S_SELECT;
        end
      end
      S_SELECT: begin
        if (pick_vld) begin
          conv_ch_d = pick_ch;
          for (int i = 0; i < NUM_CH; i++) begin
            if (3'(i) == pick_ch) serviced_d[i] = 1'b1;
          end
          state_d = S_REQ;
        end else begin
          // Commit: only channels scanned in this frame move; thresh is taken now.
          for (int i = 0; i < NUM_CH; i++) begin
            if (frame_mask_q[i]) begin
              sample_d[i] = shadow_q[i];
              line_d[i]   = (shadow_q[i] >= bus.thresh);
            end
          end
          fv_d      = 1'b1;
          gap_cnt_d = '0;
          state_d   = (bus.enable && (SCAN_GAP > 0)) ? S_GAP : S_IDLE;
        end
      end
      S_REQ: begin
        if (bus.conv_ack) begin
          to_cnt_d = '0;
          if (bus.conv_done) begin
            capture = 1'b1;
            state_d = S_SELECT;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.conv_done) begin
          capture = 1'b1;
          state_d = S_SELECT;
        end else if (32'(to_cnt_q) == TO_LAST) begin
          to_set  = 1'b1;
          state_d = S_SELECT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_GAP: begin
        if (32'(gap_cnt_q) == GAP_LAST) state_d = S_IDLE;
        else                            gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (3'(i) == conv_ch_q) shadow_d[i] = bus.conv_data;
      end
    end

    // A new timeout beats a simultaneous clear.
    err_d = to_set ? 1'b1 : (bus.err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      frame_mask_q <= '0;
      serviced_q   <= '0;
      conv_ch_q    <= '0;
      to_cnt_q     <= '0;
      gap_cnt_q    <= '0;
      shadow_q     <= '0;
      sample_q     <= '0;
      line_q       <= '0;
      fv_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_mask_q <= frame_mask_d;
      serviced_q   <= serviced_d;
      conv_ch_q    <= conv_ch_d;
      to_cnt_q     <= to_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      shadow_q     <= shadow_d;
      sample_q     <= sample_d;
      line_q       <= line_d;
      fv_q         <= fv_d;
      err_q        <= err_d;
    end
  end

  // conv_req and busy decode the state directly so reset clears them without waiting for a clock.
  assign bus.conv_req    = (state_q == S_REQ);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.conv_ch     = conv_ch_q;
  assign bus.sample_out  = sample_q;
  assign bus.line_bits   = line_q;
  assign bus.frame_valid = fv_q;
  assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_lsa_scan_scheduler.sv
// Scan scheduler bench: a behavioural ADC engine answers requests with random data, and a
// frame-level model predicts request order, committed samples and line bits.
module tb_lsa_scan_scheduler;
  localparam int NUM_CH      = 4;
  localparam int DATA_W      = 12;
  localparam int SCAN_GAP    = 16;
  localparam int TIMEOUT_CYC = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsa_scan_scheduler_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  lsa_scan_scheduler #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .SCAN_GAP(SCAN_GAP), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Stimulus knobs and model state
  logic [NUM_CH-1:0] mask_v   = '0;
  logic [DATA_W-1:0] thresh_v = '0;
  assign bus.ch_mask = mask_v;
  assign bus.thresh  = thresh_v;

  int  ack_dly  = 0;
  int  done_dly = 0;
  int  drop_ch  = -1;
  bit  use_tbl  = 1'b0;
  logic [DATA_W-1:0] tbl      [NUM_CH];
  logic [DATA_W-1:0] shadow_m [NUM_CH];
  int  n_acc    = 0;
  time ack_t [NUM_CH];

  // Behavioural ADC engine
  initial begin : engine
    int ch;
    logic [DATA_W-1:0] d;
    bus.conv_ack  = 1'b0;
    bus.conv_done = 1'b0;
    bus.conv_data = '0;
    for (int i = 0; i < NUM_CH; i++) shadow_m[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.conv_req) begin
        ch = int'(bus.conv_ch);
        for (int k = 0; k < ack_dly; k++) begin
          @(negedge clk);
          check_eq("req_hold", 64'(bus.conv_req), 64'd1);
          check_eq("ch_hold", 64'(bus.conv_ch), 64'(ch));
        end
        d = use_tbl ? tbl[ch] : DATA_W'($urandom);
        n_acc++;
        ack_t[ch] = $time;
        bus.conv_ack = 1'b1;
        if (done_dly == 0 && ch != drop_ch) begin
          bus.conv_done = 1'b1;
          bus.conv_data = d;
          shadow_m[ch]  = d;
        end
        @(negedge clk);
        bus.conv_ack  = 1'b0;
        bus.conv_done = 1'b0;
        if (done_dly > 0 && ch != drop_ch) begin
          repeat (done_dly - 1) @(negedge clk);
          bus.conv_done = 1'b1;
          bus.conv_data = d;
          shadow_m[ch]  = d;
          @(negedge clk);
          bus.conv_done = 1'b0;
        end
      end
    end
  end

  // Frame-level reference model and monitor
  int cyc = 0, frames = 0, reqs = 0, last_fv = -1, gap = 0;
  bit in_frame = 1'b0, prev_req = 1'b0, chk_gap = 1'b0, exp_idle_fv = 1'b0;
  logic [NUM_CH-1:0] fmask_m = '0;
  logic [NUM_CH-1:0] exp_line = '0;
  logic [DATA_W-1:0] exp_out [NUM_CH];
  int exp_q[$];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      in_frame = 1'b0;
      prev_req = 1'b0;
      last_fv  = -1;
      exp_q.delete();
      exp_line = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        exp_out[i]  = '0;
        shadow_m[i] = '0;
      end
    end else begin
      if (bus.conv_req && !prev_req) begin
        reqs++;
        if (!in_frame) begin
          in_frame = 1'b1;
          fmask_m  = mask_v;
          for (int i = 0; i < NUM_CH; i++) if (mask_v[i]) exp_q.push_back(i);
          if (chk_gap && last_fv >= 0) begin
            gap = cyc - last_fv;
            check_eq("frame_gap", 64'(gap >= SCAN_GAP + 1 && gap <= SCAN_GAP + 3), 64'd1);
          end
        end
        if (exp_q.size() == 0) check_eq("extra_req", 64'(exp_q.size()), 64'd1);
        else                   check_eq("req_ch", 64'(bus.conv_ch), 64'(exp_q.pop_front()));
      end
      prev_req = bus.conv_req;
      if (bus.frame_valid) begin
        frames++;
        last_fv = cyc;
        check_eq("frame_left", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < NUM_CH; i++) begin
          if (fmask_m[i]) begin
            exp_out[i]  = shadow_m[i];
            exp_line[i] = (shadow_m[i] >= thresh_v);
          end
          check_eq("sample", 64'(bus.sample_out[i*DATA_W +: DATA_W]), 64'(exp_out[i]));
        end
        check_eq("line_bits", 64'(bus.line_bits), 64'(exp_line));
        if (exp_idle_fv) check_eq("idle_after", 64'(bus.busy), 64'd0);
        in_frame = 1'b0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_ss();
    bus.single_shot = 1'b1;
    tick();
    bus.single_shot = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_frames(input int target, input int budget, input string tag);
    int k = 0;
    while (frames < target && k < budget) begin
      tick();
      k++;
    end
    check_eq(tag, 64'(frames >= target), 64'd1);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: bench did not finish, got %0d frames want completion", frames);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [NUM_CH*DATA_W-1:0] exp1;
    logic [NUM_CH*DATA_W-1:0] so;
    logic [NUM_CH-1:0]        lb;
    int f0, r0, a0, k;
    bit found, saw_busy;

    bus.enable      = 1'b0;
    bus.single_shot = 1'b0;
    bus.err_clr     = 1'b0;
    tick(3);
    check_eq("rst_req",   64'(bus.conv_req), 64'd0);
    check_eq("rst_busy",  64'(bus.busy), 64'd0);
    check_eq("rst_fv",    64'(bus.frame_valid), 64'd0);
    check_eq("rst_err",   64'(bus.timeout_err), 64'd0);
    check_eq("rst_samp",  64'(bus.sample_out), 64'd0);
    check_eq("rst_line",  64'(bus.line_bits), 64'd0);
    rst = 1'b0;
    tick(2);

    // Fixed-data frame, all channels
    use_tbl = 1'b1;
    tbl[0] = 12'h100; tbl[1] = 12'h900; tbl[2] = 12'h7FF; tbl[3] = 12'h800;
    thresh_v = 12'h800;
    mask_v   = 4'b1111;
    done_dly = 3;
    pulse_ss();
    wait_frames(1, 300, "t1_frame");
    exp1 = {12'h800, 12'h7FF, 12'h900, 12'h100};
    check_eq("t1_line", 64'(bus.line_bits), 64'(4'b1010));
    check_eq("t1_samp", 64'(bus.sample_out), 64'(exp1));
    check_eq("t1_reqs", 64'(reqs), 64'd4);
    tick(5);
    check_eq("t1_idle", 64'(bus.busy), 64'd0);

    // Random data; a second single_shot while busy must be ignored
    use_tbl  = 1'b0;
    thresh_v = DATA_W'($urandom);
    done_dly = $urandom_range(0, 6);
    pulse_ss();
    tick(3);
    check_eq("ss_busy", 64'(bus.busy), 64'd1);
    pulse_ss();
    wait_frames(2, 300, "t1b_frame");
    tick(40);
    check_eq("ss_ignored", 64'(frames), 64'd2);
    check_eq("ss_idle", 64'(bus.busy), 64'd0);

    // Continuous mode with a partial mask, mask change between frames, enable drop mid-frame
    do_reset();
    f0 = frames;
    mask_v   = 4'b0101;
    thresh_v = DATA_W'($urandom);
    done_dly = $urandom_range(1, 6);
    chk_gap  = 1'b1;
    bus.enable = 1'b1;
    wait_frames(f0 + 1, 300, "t2_frame1");
    check_eq("t2_ch1_zero", 64'(bus.sample_out[1*DATA_W +: DATA_W]), 64'd0);
    check_eq("t2_ch3_zero", 64'(bus.sample_out[3*DATA_W +: DATA_W]), 64'd0);
    mask_v   = 4'b0010;
    done_dly = 10;
    wait_frames(f0 + 2, 300, "t2_frame2");
    found = 1'b0;
    for (k = 0; k < 200 && !found; k++) begin
      tick();
      found = bus.conv_req;
    end
    check_eq("t2_restart", 64'(found), 64'd1);
    bus.enable  = 1'b0;
    exp_idle_fv = 1'b1;
    wait_frames(f0 + 3, 300, "t2_frame3");
    tick(30);
    check_eq("t2_stop", 64'(frames - f0), 64'd3);
    chk_gap     = 1'b0;
    exp_idle_fv = 1'b0;

    // Slow acknowledge: request held five cycles, one conversion per channel
    mask_v   = 4'b1111;
    ack_dly  = 5;
    done_dly = $urandom_range(0, 4);
    f0 = frames; r0 = reqs; a0 = n_acc;
    pulse_ss();
    wait_frames(f0 + 1, 500, "t3_frame");
    check_eq("t3_acks", 64'(n_acc - a0), 64'd4);
    check_eq("t3_reqs", 64'(reqs - r0), 64'd4);
    ack_dly = 0;

    // Channel 2 never answers
    drop_ch  = 2;
    done_dly = 2;
    f0 = frames;
    pulse_ss();
    found = 1'b0;
    for (k = 0; k < 2000 && !found; k++) begin
      tick();
      found = bus.timeout_err;
    end
    check_eq("t4_err_set", 64'(found), 64'd1);
    k = int'(($time - ack_t[2]) / 10);
    check_eq("t4_to_len", 64'(k >= TIMEOUT_CYC && k <= TIMEOUT_CYC + 2), 64'd1);
    wait_frames(f0 + 1, 300, "t4_frame");
    check_eq("t4_sticky", 64'(bus.timeout_err), 64'd1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    tick();
    check_eq("t4_err_clr", 64'(bus.timeout_err), 64'd0);
    drop_ch = -1;

    // Reset while waiting on channel 1
    drop_ch = 1;
    pulse_ss();
    found = 1'b0;
    for (k = 0; k < 500 && !found; k++) begin
      tick();
      found = (bus.conv_ch == 3'd1) && bus.busy && !bus.conv_req;
    end
    check_eq("t5_in_wait", 64'(found), 64'd1);
    tick(10);
    f0 = frames;
    #1 rst = 1'b1;
    #1;
    check_eq("t5_req",  64'(bus.conv_req), 64'd0);
    check_eq("t5_busy", 64'(bus.busy), 64'd0);
    check_eq("t5_samp", 64'(bus.sample_out), 64'd0);
    check_eq("t5_line", 64'(bus.line_bits), 64'd0);
    check_eq("t5_fv",   64'(bus.frame_valid), 64'd0);
    tick(3);
    rst = 1'b0;
    drop_ch = -1;
    tick(3);
    check_eq("t5_nofv", 64'(frames - f0), 64'd0);
    done_dly = $urandom_range(0, 5);
    thresh_v = DATA_W'($urandom);
    pulse_ss();
    wait_frames(f0 + 1, 300, "t5_frame");

    // Empty mask and a stray conv_done in IDLE
    tick(5);
    mask_v = '0;
    f0 = frames; r0 = reqs;
    pulse_ss();
    saw_busy = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      saw_busy = saw_busy | bus.busy;
    end
    check_eq("t6_busy",   64'(saw_busy), 64'd0);
    check_eq("t6_reqs",   64'(reqs - r0), 64'd0);
    check_eq("t6_frames", 64'(frames - f0), 64'd0);
    so = bus.sample_out;
    lb = bus.line_bits;
    bus.conv_done = 1'b1;
    bus.conv_data = DATA_W'($urandom);
    tick();
    bus.conv_done = 1'b0;
    tick(3);
    check_eq("t6_samp", 64'(bus.sample_out), 64'(so));
    check_eq("t6_line", 64'(bus.line_bits), 64'(lb));
    check_eq("t6_fv",   64'(frames - f0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
